// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle binary32 adder sequencer driving a shared external 24-bit right shifter.
// Define FPADD_SPECIAL_EN to bypass Inf/NaN operands; otherwise exp==255 inputs are treated as finite.
module fp_add_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic [23:0] shift_in,
  output logic [4:0]  shift_amt,
  input  logic [23:0] shift_out
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state_reg;
  logic        sign_reg;
  logic        sub_reg;
  logic [8:0]  exp_reg;
  logic [23:0] sig_l_reg;
  logic [23:0] sig_s_reg;
  logic [7:0]  d_reg;
  logic [24:0] sum_reg;

  logic        a_zero;
  logic        b_zero;
  logic        a_is_l;
  logic        bypass;
  logic [31:0] l_op;
  logic [31:0] s_op;
  logic [31:0] bypass_res;
  logic [7:0]  d_in;
  logic [23:0] sig_s_in;
  logic [24:0] sum_next;

`ifdef FPADD_SPECIAL_EN
  logic a_spec;
  logic b_spec;
  logic a_nan;
  logic b_nan;
  assign a_spec = (a[30:23] == 8'hFF);
  assign b_spec = (b[30:23] == 8'hFF);
  assign a_nan  = a_spec && (a[22:0] != 23'd0);
  assign b_nan  = b_spec && (b[22:0] != 23'd0);
`endif

  always_comb begin
    a_zero     = (a[30:23] == 8'd0);
    b_zero     = (b[30:23] == 8'd0);
    // Magnitude order on {exp,frac}; a tie keeps a as the larger operand.
    a_is_l     = (a[30:0] >= b[30:0]);
    l_op       = a_is_l ? a : b;
    s_op       = a_is_l ? b : a;
    d_in       = l_op[30:23] - s_op[30:23];
    sig_s_in   = {1'b1, s_op[22:0]};
    bypass     = a_zero | b_zero;
    bypass_res = a_zero ? (b_zero ? 32'd0 : b) : a;
`ifdef FPADD_SPECIAL_EN
    if (a_spec || b_spec) begin
      bypass = 1'b1;
      if (a_nan || b_nan || (a_spec && b_spec && (a[31] != b[31])))
        bypass_res = 32'h7FC00000;
      else if (a_spec)
        bypass_res = a;
      else
        bypass_res = b;
    end
`endif
    sum_next = sub_reg ? ({1'b0, sig_l_reg} - {1'b0, sig_s_reg})
                       : ({1'b0, sig_l_reg} + {1'b0, sig_s_reg});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 32'd0;
      ovf       <= 1'b0;
      shift_in  <= 24'd0;
      shift_amt <= 5'd0;
      sign_reg  <= 1'b0;
      sub_reg   <= 1'b0;
      exp_reg   <= 9'd0;
      sig_l_reg <= 24'd0;
      sig_s_reg <= 24'd0;
      d_reg     <= 8'd0;
      sum_reg   <= 25'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            ovf      <= 1'b0;
            if (bypass) begin
              result    <= bypass_res;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end else begin
              sign_reg  <= l_op[31];
              sub_reg   <= a[31] ^ b[31];
              exp_reg   <= {1'b0, l_op[30:23]};
              sig_l_reg <= {1'b1, l_op[22:0]};
              sig_s_reg <= sig_s_in;
              d_reg     <= d_in;
              // Shifter operands are registered so they are stable for the whole ALIGN cycle.
              shift_in  <= sig_s_in;
              shift_amt <= (d_in < 8'd24) ? d_in[4:0] : 5'd0;
              state_reg <= ALIGN;
            end
          end
        end
        ALIGN: begin
          sig_s_reg <= (d_reg >= 8'd24) ? 24'd0 : shift_out;
          shift_in  <= 24'd0;
          shift_amt <= 5'd0;
          state_reg <= ADD;
        end
        ADD: begin
          if (sum_next == 25'd0) begin
            result    <= 32'd0;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            sum_reg   <= sum_next;
            state_reg <= NORM;
          end
        end
        NORM: begin
          if (sum_reg[24]) begin
            if (exp_reg >= 9'd254) begin
              result <= {sign_reg, 8'hFF, 23'd0};
              ovf    <= 1'b1;
            end else begin
              result <= {sign_reg, exp_reg[7:0] + 8'd1, sum_reg[23:1]};
            end
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else if (sum_reg[23]) begin
            if (exp_reg >= 9'd255) begin
              result <= {sign_reg, 8'hFF, 23'd0};
              ovf    <= 1'b1;
            end else begin
              result <= {sign_reg, exp_reg[7:0], sum_reg[22:0]};
            end
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            sum_reg <= {sum_reg[23:0], 1'b0};
            exp_reg <= exp_reg - 9'd1;
            // Underflow: the exponent hits zero before the sum is normalized.
            if (exp_reg == 9'd1) begin
              result    <= {sign_reg, 31'd0};
              out_valid <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Self-checking bench for fp_add_seq_ctrl with a behavioural binary32 truncating-add model.
// Latency below counts clock edges after the accept edge until out_valid is seen (bypass = next cycle).
module tb_fp_add_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic [23:0] shift_in;
  logic [4:0]  shift_amt;
  logic [23:0] shift_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign shift_out = shift_in >> shift_amt;

  fp_add_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .shift_in(shift_in), .shift_amt(shift_amt),
    .shift_out(shift_out)
  );

  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic o,
                                output int lat, output int amt);
    int ex, ey, fx, fy, el, es, fl, fs, d, sl, ss, mag, k, e;
    logic sgn, sub;
    logic [31:0] lw;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = int'(x[22:0]);  fy = int'(y[22:0]);
    r = 32'd0; o = 1'b0; lat = 0; amt = 0;
`ifdef FPADD_SPECIAL_EN
    if (ex == 255 || ey == 255) begin
      if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0) || (ex == 255 && ey == 255 && x[31] != y[31]))
        r = 32'h7FC00000;
      else if (ex == 255) r = x;
      else r = y;
      return;
    end
`endif
    if (ex == 0 || ey == 0) begin
      r = (ex != 0) ? x : ((ey != 0) ? y : 32'd0);
      return;
    end
    if (x[30:0] >= y[30:0]) begin
      lw = x; el = ex; fl = fx; es = ey; fs = fy;
    end else begin
      lw = y; el = ey; fl = fy; es = ex; fs = fx;
    end
    sgn = lw[31];
    sub = x[31] ^ y[31];
    d = el - es;
    amt = (d < 24) ? d : 0;
    sl = 32'h800000 + fl;
    ss = (d < 24) ? ((32'h800000 + fs) >> d) : 0;
    mag = sub ? sl - ss : sl + ss;
    if (mag == 0) begin lat = 2; return; end
    if (mag >= (1 << 24)) begin
      lat = 3; e = el + 1;
      if (e >= 255) begin r = {sgn, 8'hFF, 23'd0}; o = 1'b1; end
      else r = {sgn, 8'(e), 23'((mag >> 1) & 32'h7FFFFF)};
      return;
    end
    k = 0;
    while (mag < (1 << 23)) begin mag = mag << 1; k++; end
    if (k >= el) begin lat = 2 + el; r = {sgn, 31'd0}; return; end
    lat = 3 + k; e = el - k;
    if (e >= 255) begin r = {sgn, 8'hFF, 23'd0}; o = 1'b1; end
    else r = {sgn, 8'(e), 23'(mag & 32'h7FFFFF)};
  endfunction

  // Drives one operation, observes it, and completes the result handshake.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic o, output int lat,
                        output int amt, output logic [23:0] sin, output logic busy_ok);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    amt = int'(shift_amt); sin = shift_in; busy_ok = 1'b1; lat = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (in_ready !== 1'b0) busy_ok = 1'b0;
    r = result; o = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || ovf !== 1'b0 ||
        shift_in !== 24'd0 || shift_amt !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h ovf=%b shift_in=%h shift_amt=%0d, required 1 0 00000000 0 000000 0",
               in_ready, out_valid, result, ovf, shift_in, shift_amt);
    end
    $display("test_reset: in_ready=%b out_valid=%b result=%h", in_ready, out_valid, result);
  endtask

  task automatic test_directed();
    logic [31:0] va [10], vb [10], vr [10];
    logic        vo [10];
    int          vl [10], vm [10];
    logic [31:0] r; logic o; int lat, amt; logic [23:0] sin; logic bz;
    va = '{32'h3F800000, 32'h3F800000, 32'h4B800000, 32'h7F7FFFFF, 32'h40400000,
           32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00800000, 32'h00400000};
    vb = '{32'h3F800000, 32'hBF400000, 32'h3F800000, 32'h7F7FFFFF, 32'hC0400000,
           32'h00000000, 32'h40000000, 32'hC0000000, 32'h80C00000, 32'h3F800000};
    vr = '{32'h40000000, 32'h3E800000, 32'h4B800000, 32'h7F800000, 32'h00000000,
           32'h3F800000, 32'h40400000, 32'hBF800000, 32'h80000000, 32'h3F800000};
    vo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vl = '{3, 5, 3, 3, 2, 0, 3, 4, 3, 0};
    vm = '{0, 1, -1, 0, 0, -1, 1, 1, 0, -1};
    for (int i = 0; i < 10; i++) begin
      run_op(va[i], vb[i], r, o, lat, amt, sin, bz);
      $display("directed %0d: %h + %h -> %h ovf=%b lat=%0d amt=%0d", i, va[i], vb[i], r, o, lat, amt);
      checks++;
      if (r !== vr[i] || o !== vo[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h ovf=%b, required %h ovf=%b", i, r, o, vr[i], vo[i]);
      end
      checks++;
      if (lat != vl[i] || !bz) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d busy_ok=%b, required %0d busy_ok=1", i, lat, bz, vl[i]);
      end
      if (vm[i] >= 0) begin
        checks++;
        if (amt != vm[i]) begin
          errors++;
          $display("FAIL directed_shift_amt[%0d]: got %0d, required %0d", i, amt, vm[i]);
        end
      end
      if (i == 0) begin
        checks++;
        if (sin !== 24'h800000) begin
          errors++;
          $display("FAIL directed_shift_in: got %h, required 800000", sin);
        end
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [3], vb [3], vr [3];
    logic        vo [3];
    int          vl [3];
    logic [31:0] r; logic o; int lat, amt; logic [23:0] sin; logic bz;
    va = '{32'h7F800000, 32'h7FC00001, 32'hFF800000};
    vb = '{32'hFF800000, 32'h3F800000, 32'h3F800000};
`ifdef FPADD_SPECIAL_EN
    vr = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000};
    vo = '{1'b0, 1'b0, 1'b0};
    vl = '{0, 0, 0};
`else
    vr = '{32'h00000000, 32'h7F800000, 32'hFF800000};
    vo = '{1'b0, 1'b1, 1'b1};
    vl = '{2, 3, 3};
`endif
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], r, o, lat, amt, sin, bz);
      $display("special %0d: %h + %h -> %h ovf=%b lat=%0d", i, va[i], vb[i], r, o, lat);
      checks++;
      if (r !== vr[i] || o !== vo[i] || lat != vl[i]) begin
        errors++;
        $display("FAIL special[%0d]: got %h ovf=%b lat=%0d, required %h ovf=%b lat=%0d",
                 i, r, o, lat, vr[i], vo[i], vl[i]);
      end
    end
  endtask

  task automatic test_hold();
    int n;
    a = 32'h40000000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h40400000 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: out_valid=%b result=%h in_ready=%b, required 1 40400000 0",
                 c, out_valid, result, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    $display("test_hold: result held 40400000 for 5 cycles, lat=%0d", n);
  endtask

  task automatic test_reset_mid();
    a = 32'h3F800000; b = 32'hBF400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || ovf !== 1'b0 ||
        shift_in !== 24'd0 || shift_amt !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b result=%h ovf=%b shift_in=%h shift_amt=%0d, required 1 0 00000000 0 000000 0",
               in_ready, out_valid, result, ovf, shift_in, shift_amt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("test_reset_mid: reset asserted during NORM, outputs cleared");
  endtask

  task automatic test_random();
    logic [31:0] x, y, r, er; logic o, eo; int lat, el, amt, eamt; logic [23:0] sin; logic bz;
    int ea, eb, sel;
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 9));
      ea = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(1, 254));
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      if ($urandom_range(0, 15) == 0) eb = 0;
      x = {1'($urandom), 8'(ea), 23'($urandom)};
      y = {1'($urandom), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) y = {~x[31], x[30:0]};
      model(x, y, er, eo, el, eamt);
      run_op(x, y, r, o, lat, amt, sin, bz);
      $display("random %0d: %h + %h -> %h ovf=%b lat=%0d (model %h %b %0d)", i, x, y, r, o, lat, er, eo, el);
      checks++;
      if (r !== er || o !== eo || lat != el || !bz) begin
        errors++;
        $display("FAIL random[%0d] %h+%h: got %h ovf=%b lat=%0d busy_ok=%b, required %h ovf=%b lat=%0d",
                 i, x, y, r, o, lat, bz, er, eo, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, r, er; logic o, eo; int lat, el, amt, eamt; logic [23:0] sin; logic bz;
    for (int i = 0; i < 4; i++) begin
      x = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      y = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      model(x, y, er, eo, el, eamt);
      run_op(x, y, r, o, lat, amt, sin, bz);
      $display("b2b %0d: %h + %h -> %h lat=%0d", i, x, y, r, lat);
      checks++;
      if (r !== er || o !== eo || lat != el || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h ovf=%b lat=%0d in_ready=%b, required %h ovf=%b lat=%0d in_ready=1",
                 i, r, o, lat, in_ready, er, eo, el);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_special();
    test_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
